// File: rtl/bus_pkg.sv
// Shared bus definitions used by the arbiter and the master port timeout logic.
//   - arb_state_e  : arbiter FSM encoding (IDLE=0, OWNED=1, RELEASE=2)
//   - NUM_MASTERS  : number of masters sharing the serial bus
//   - DEFAULT_TIMEOUT / DEFAULT_TCNT_W : default grant hold limit and its counter width
//   - owner_onehot : converts a master index into a one-hot grant vector
package bus_pkg;

    localparam int NUM_MASTERS     = 2;
    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_TCNT_W  = 6;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OWNED   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    function automatic logic [NUM_MASTERS-1:0] owner_onehot(input logic idx);
        owner_onehot      = '0;
        owner_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration signals between the two masters and the bus arbiter.
//   req         : per-master request level, held for the whole transaction
//   txn_done    : one-cycle pulse, active transaction finished
//   grant       : one-hot registered grant, 00 when the bus is free
//   mstr_sel    : index of current or last owner (bus mux select)
//   bus_busy    : a grant is active
//   timeout_err : one-cycle pulse on forced release
// Modports: slave = arbiter side, master = requesting side.
interface bus_arbiter_if;
    import bus_pkg::*;

    logic [NUM_MASTERS-1:0] req;
    logic                   txn_done;
    logic [NUM_MASTERS-1:0] grant;
    logic                   mstr_sel;
    logic                   bus_busy;
    logic                   timeout_err;

    modport slave  (input  req, txn_done,
                    output grant, mstr_sel, bus_busy, timeout_err);
    modport master (output req, txn_done,
                    input  grant, mstr_sel, bus_busy, timeout_err);
endinterface

// File: rtl/arb_timeout_counter.sv
// Grant hold-time counter for the bus arbiter.
//   clk, reset : bus clock, asynchronous active-high reset
//   clr        : reload to zero (takes priority over en)
//   en         : count one cycle of ownership
//   tc         : count has reached TIMEOUT-1
module arb_timeout_counter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TCNT_W  = DEFAULT_TCNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (clr)     tcnt_d = '0;
        else if (en) tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tcnt_q <= '0;
        else       tcnt_q <= tcnt_d;
    end

    assign tc = (tcnt_q == TCNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter.
// Grants one master at a time, holds the grant until txn_done, owner release
// or timeout, then spends one RELEASE cycle with no grant before returning
// to IDLE, so two grants are always separated by at least two free cycles.
// Ports:
//   clk   : bus clock, rising edge
//   reset : asynchronous, active-high; drops grant without waiting for an edge
//   bus   : bus_arbiter_if.slave (req, txn_done in; grant, mstr_sel,
//           bus_busy, timeout_err out)
// Build option: ARB_ROUND_ROBIN_EN - on a tie the master that did not own the
// bus last wins; without it master 0 always wins ties.
// TIMEOUT must be >= 16 and 2**TCNT_W >= TIMEOUT.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TCNT_W  = DEFAULT_TCNT_W
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   mstr_sel_q, mstr_sel_d;
    logic                   last_owner_q, last_owner_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   winner;
    logic                   tcnt_clr, tcnt_en, tcnt_tc;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TCNT_W  (TCNT_W)
    ) u_tcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (tcnt_clr),
        .en    (tcnt_en),
        .tc    (tcnt_tc)
    );

    // Only meaningful when some request is present.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (&bus.req) winner = ~last_owner_q;
        else          winner = ~bus.req[0];
`else
        winner = ~bus.req[0];
`endif
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mstr_sel_d    = mstr_sel_q;
        last_owner_d  = last_owner_q;
        timeout_err_d = 1'b0;
        tcnt_clr      = 1'b0;
        tcnt_en       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|bus.req) begin
                    state_d    = ARB_OWNED;
                    grant_d    = owner_onehot(winner);
                    mstr_sel_d = winner;
                    tcnt_clr   = 1'b1;
                end
            end
            ARB_OWNED: begin
                tcnt_en = 1'b1;
                // Completion and abandon outrank the timeout, so a txn_done
                // landing on the terminal count is a clean finish.
                if (bus.txn_done || !bus.req[mstr_sel_q]) begin
                    state_d = ARB_RELEASE;
                    grant_d = '0;
                end else if (tcnt_tc) begin
                    state_d       = ARB_RELEASE;
                    grant_d       = '0;
                    timeout_err_d = 1'b1;
                end
            end
            ARB_RELEASE: begin
                state_d      = ARB_IDLE;
                last_owner_d = mstr_sel_q;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            mstr_sel_q    <= 1'b0;
            last_owner_q  <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mstr_sel_q    <= mstr_sel_d;
            last_owner_q  <= last_owner_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.mstr_sel    = mstr_sel_q;
    assign bus.bus_busy    = |grant_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed reset checks, then directed and
// random request/done traffic; a transaction-level model predicts the bus
// outputs after every edge and a monitor compares them.
module tb_bus_arbiter;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT(TIMEOUT), .TCNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] grant;
        logic       busy;
        logic       sel;
        logic       terr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    // Reference model: who owns the bus, how many cycles it has owned it,
    // whether the post-release free cycle is pending, who owned it last.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_last  = 1;
    bit   m_rel   = 0;
    logic m_sel   = 1'b0;
    logic m_terr  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [1:0] req, input logic done);
        exp_t e;
        m_terr = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (done || !req[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_rel = 1;
            end else if (m_held == TIMEOUT) begin
                m_last = m_owner; m_owner = -1; m_rel = 1; m_terr = 1'b1;
            end
        end else if (m_rel) begin
            m_rel = 0;
        end else if (req != 2'b00) begin
            if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
                m_owner = (m_last == 0) ? 1 : 0;
`else
                m_owner = 0;
`endif
            end else begin
                m_owner = req[0] ? 0 : 1;
            end
            m_sel  = (m_owner == 1);
            m_held = 0;
        end
        e.grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e.busy  = (m_owner >= 0);
        e.sel   = m_sel;
        e.terr  = m_terr;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] req, input logic done);
        @(negedge clk);
        bus.req      = req;
        bus.txn_done = done;
        model_step(req, done);
    endtask

    // Monitor: compares each post-edge output set against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("grant",       bus.grant,       e.grant);
                check("bus_busy",    bus.bus_busy,    e.busy);
                check("mstr_sel",    bus.mstr_sel,    e.sel);
                check("timeout_err", bus.timeout_err, e.terr);
                check("grant_not_11", bus.grant != 2'b11, 1);
            end
        end
    end

    initial begin
        logic [1:0] r;
        logic       d;
        reset        = 1'b1;
        bus.req      = 2'b00;
        bus.txn_done = 1'b0;

        // Reset values
        #12;
        check("rst_grant", bus.grant, 2'b00);
        check("rst_busy",  bus.bus_busy, 1'b0);
        check("rst_sel",   bus.mstr_sel, 1'b0);
        check("rst_terr",  bus.timeout_err, 1'b0);
        @(negedge clk); reset = 1'b0;

        // Grant, then asynchronous reset between edges
        @(negedge clk); bus.req = 2'b01;
        @(posedge clk); #1;
        check("pre_rst_grant", bus.grant, 2'b01);
        check("pre_rst_busy",  bus.bus_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_grant", bus.grant, 2'b00);
        check("async_rst_busy",  bus.bus_busy, 1'b0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_regrant", bus.grant, 2'b01);

        // Clean restart for the scoreboard phase
        @(negedge clk); reset = 1'b1; bus.req = 2'b00;
        @(negedge clk); reset = 1'b0;
        m_owner = -1; m_held = 0; m_last = 1; m_rel = 0; m_sel = 1'b0;
        mon_en  = 1;

        // Single master, done after the 10th owned cycle
        for (int i = 0; i < 16; i++) drive(2'b01, m_owner == 0 && m_held == 9);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);

        // Contention, both held, done after each short transaction
        for (int i = 0; i < 40; i++) drive(2'b11, m_owner >= 0 && m_held == 4);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);

        // Timeout on master 1, then regrant
        for (int i = 0; i < 150; i++) drive(2'b10, 1'b0);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);

        // txn_done on the terminal count is a normal completion
        for (int i = 0; i < 140; i++) drive(2'b01, m_owner >= 0 && m_held == TIMEOUT - 1);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);

        // Owner abandons, non-owner waiting; stray done in free cycles
        for (int i = 0; i < 6; i++) drive(2'b11, 1'b0);
        drive(2'b10, 1'b0);
        drive(2'b10, 1'b1);
        drive(2'b10, 1'b1);
        for (int i = 0; i < 6; i++) drive(2'b10, 1'b0);

        // Random traffic: busy phase then long-hold phase
        r = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11) == 0) r[0] = ~r[0];
            if ($urandom_range(11) == 0) r[1] = ~r[1];
            d = (i < 1500) ? ($urandom_range(9) == 0) : ($urandom_range(199) == 0);
            drive(r, d);
        end
        drive(2'b00, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
